// File: rtl/sdram_port_sched_pkg.sv
// -----------------------------------------------------------------------------
// sdram_sched_pkg
// Shared definitions for the SDRAM port scheduler slice:
//   - sched_state_t : scheduler FSM encoding (LOAD=0, DRAIN=1, SETTLE=2, RUN=3)
//   - PH_RUN        : nes_ce phase on which the NES runs and loader writes issue
//   - DEFAULT_ADDR_W: default byte address width toward the sdram block
//   - sum_add       : 16-bit running byte checksum step (load verification)
// Optional feature macro used by this slice: SDRAM_VERIFY_EN
// -----------------------------------------------------------------------------
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } sched_state_t;

    localparam logic [1:0] PH_RUN         = 2'd3;
    localparam int         DEFAULT_ADDR_W = 22;

    // Modulo-2^16 accumulate of one loaded byte.
    function automatic logic [15:0] sum_add(input logic [15:0] acc, input logic [7:0] b);
        return acc + {8'd0, b};
    endfunction

endpackage

// File: rtl/sdram_port_sched_if.sv
// -----------------------------------------------------------------------------
// sdram_port_sched_if
// Bundles the loader, NES and sdram-side signals of sdram_port_sched.
//   master : the surroundings (game_loader, NES, sdram) - drives loader/NES
//            requests, observes scheduler outputs
//   slave  : the scheduler itself
// Clock and reset are kept out of the bundle as plain ports.
// -----------------------------------------------------------------------------
interface sdram_port_sched_if #(
    parameter int ADDR_W = sdram_sched_pkg::DEFAULT_ADDR_W
) ();

    // loader side
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              reload;
    // NES side
    logic [ADDR_W-1:0] nes_addr;
    logic              nes_rd_cpu;
    logic              nes_rd_ppu;
    logic              nes_wr;
    logic [7:0]        nes_dout;
    logic [1:0]        nes_ce;
    logic              run_nes;
    logic              nes_reset;
    // sdram request port
    logic [ADDR_W-1:0] sd_addr;
    logic              sd_we;
    logic [7:0]        sd_din;
    logic              sd_oeA;
    logic              sd_oeB;
    logic              sd_clkref;
    // status
    logic              overflow;
    logic              loaded;

    modport master (
        output ld_valid, ld_addr, ld_data, ld_done, reload,
        output nes_addr, nes_rd_cpu, nes_rd_ppu, nes_wr, nes_dout,
        input  ld_ready, nes_ce, run_nes, nes_reset,
        input  sd_addr, sd_we, sd_din, sd_oeA, sd_oeB, sd_clkref,
        input  overflow, loaded
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_done, reload,
        input  nes_addr, nes_rd_cpu, nes_rd_ppu, nes_wr, nes_dout,
        output ld_ready, nes_ce, run_nes, nes_reset,
        output sd_addr, sd_we, sd_din, sd_oeA, sd_oeB, sd_clkref,
        output overflow, loaded
    );

endinterface

// File: rtl/sdram_port_sched_ld_wr_fifo.sv
// -----------------------------------------------------------------------------
// ld_wr_fifo
// Small synchronous first-word-fall-through FIFO buffering loader writes.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset (pointers/count)
//   flush          : synchronous clear (reload)
//   push, wdata    : write one entry (accepted when not full, or when a pop
//                    happens on the same clock)
//   pop            : drop the head entry (ignored when empty)
//   rdata          : head entry, valid while !empty
//   full, empty, count : occupancy
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module ld_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/sdram_port_sched.sv
// -----------------------------------------------------------------------------
// sdram_port_sched
// Owns the single SDRAM request port and the NES clock-enable phase. Loader
// byte writes are buffered and issued one per NES slot (on nes_ce==3 edges)
// while the NES is held in reset; once loading has drained and settled for
// SETTLE_SLOTS slots the port is handed to the NES as a zero-latency mux.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus (slave)    : loader handshake, NES requests, nes_ce/run_nes/nes_reset,
//                    sdram request outputs, overflow/loaded status
//   load_sum       : (SDRAM_VERIFY_EN only) running 16-bit sum of written bytes
// Optional feature macro: SDRAM_VERIFY_EN - adds load_sum and inserts an idle
// slot after each loader write slot.
// -----------------------------------------------------------------------------
module sdram_port_sched #(
    parameter int LD_FIFO_DEPTH = 4,
    parameter int SETTLE_SLOTS  = 8,
    parameter int ADDR_W        = sdram_sched_pkg::DEFAULT_ADDR_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sdram_port_sched_if.slave    bus
`ifdef SDRAM_VERIFY_EN
    ,
    output logic [15:0]          load_sum
`endif
);

    import sdram_sched_pkg::*;

    localparam int            CW          = $clog2(LD_FIFO_DEPTH) + 1;
    localparam int            SW          = $clog2(SETTLE_SLOTS + 2);
    localparam logic [CW-1:0] CNT_FULL    = CW'(LD_FIFO_DEPTH);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_SLOTS);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1'b1);

    sched_state_t      state_r;
    sched_state_t      state_s;
    logic [SW-1:0]     settle_cnt_r;
    logic [SW-1:0]     settle_cnt_s;
    logic [1:0]        nes_ce_r;
    logic              reload_q_r;
    logic              reload_rise_s;
    logic              slot_s;
    logic              wr_state_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     cnt_next_s;
    logic [ADDR_W+7:0] fifo_rdata_s;
    logic              wr_we_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        wr_din_r;
    logic              overflow_r;
    logic              ld_ready_r;
    logic              ld_ready_s;

    assign reload_rise_s = bus.reload && !reload_q_r;
    assign slot_s        = (nes_ce_r == PH_RUN);
    assign wr_state_s    = (state_r == LOAD) || (state_r == DRAIN);

    // Loader bytes are only taken in LOAD; a reload edge flushes instead.
    assign push_s = bus.ld_valid && !full_s && (state_r == LOAD) && !reload_rise_s;

`ifdef SDRAM_VERIFY_EN
    // A slot that just carried a write is followed by an idle slot.
    assign pop_s = slot_s && wr_state_s && !empty_s && !wr_we_r && !reload_rise_s;
`else
    assign pop_s = slot_s && wr_state_s && !empty_s && !reload_rise_s;
`endif

    ld_wr_fifo #(
        .DEPTH (LD_FIFO_DEPTH),
        .WIDTH (ADDR_W + 8)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (reload_rise_s),
        .push    (push_s),
        .wdata   ({bus.ld_addr, bus.ld_data}),
        .pop     (pop_s),
        .rdata   (fifo_rdata_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // Free-running NES phase counter and reload edge detector.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nes_ce_r   <= 2'd0;
            reload_q_r <= 1'b0;
        end else begin
            nes_ce_r   <= nes_ce_r + 2'd1;
            reload_q_r <= bus.reload;
        end
    end

    // Next state and settle countdown.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        if (reload_rise_s) begin
            state_s = LOAD;
        end else begin
            case (state_r)
                LOAD: begin
                    if (bus.ld_done) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = LOAD;
                    end
                end
                DRAIN: begin
                    // Leave only on a slot boundary with nothing queued or in flight.
                    if (slot_s && empty_s && !wr_we_r) begin
                        state_s      = SETTLE;
                        settle_cnt_s = SETTLE_INIT;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                SETTLE: begin
                    if (slot_s) begin
                        if (settle_cnt_r <= SETTLE_ONE) begin
                            state_s      = RUN;
                            settle_cnt_s = {SW{1'b0}};
                        end else begin
                            settle_cnt_s = settle_cnt_r - SETTLE_ONE;
                        end
                    end else begin
                        settle_cnt_s = settle_cnt_r;
                    end
                end
                RUN: begin
                    state_s = RUN;
                end
                default: begin
                    state_s = LOAD;
                end
            endcase
        end
    end

    // State and settle counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= LOAD;
            settle_cnt_r <= {SW{1'b0}};
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
        end
    end

    // Occupancy after this clock, used to register ld_ready.
    always_comb begin
        cnt_next_s = count_s;
        if (reload_rise_s) begin
            cnt_next_s = {CW{1'b0}};
        end else begin
            cnt_next_s = count_s + {{(CW - 1){1'b0}}, push_s} - {{(CW - 1){1'b0}}, pop_s};
        end
        ld_ready_s = (state_s == LOAD) && (cnt_next_s != CNT_FULL);
    end

    // Loader write slot: loaded on a slot edge, held until the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_we_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_din_r  <= 8'd0;
        end else if (reload_rise_s) begin
            wr_we_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_din_r  <= 8'd0;
        end else if (slot_s) begin
            if (pop_s) begin
                wr_we_r   <= 1'b1;
                wr_addr_r <= fifo_rdata_s[ADDR_W+7:8];
                wr_din_r  <= fifo_rdata_s[7:0];
            end else begin
                wr_we_r   <= 1'b0;
            end
        end else begin
            wr_we_r   <= wr_we_r;
        end
    end

    // Sticky overflow flag and registered ld_ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
            ld_ready_r <= 1'b0;
        end else begin
            ld_ready_r <= ld_ready_s;
            if (reload_rise_s) begin
                overflow_r <= 1'b0;
            end else if (bus.ld_valid && full_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

`ifdef SDRAM_VERIFY_EN
    logic [15:0] load_sum_r;

    // Running checksum of every byte written during loading.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_sum_r <= 16'd0;
        end else if (reload_rise_s) begin
            load_sum_r <= 16'd0;
        end else if (pop_s) begin
            load_sum_r <= sum_add(load_sum_r, fifo_rdata_s[7:0]);
        end else begin
            load_sum_r <= load_sum_r;
        end
    end

    assign load_sum = load_sum_r;
`endif

    // Port mux: NES traffic passes straight through in RUN so NES timing is
    // unchanged; otherwise the registered loader slot drives the port.
    always_comb begin
        bus.sd_addr = wr_addr_r;
        bus.sd_din  = wr_din_r;
        bus.sd_we   = wr_we_r;
        bus.sd_oeA  = 1'b0;
        bus.sd_oeB  = 1'b0;
        if (state_r == RUN) begin
            bus.sd_addr = bus.nes_addr;
            bus.sd_din  = bus.nes_dout;
            bus.sd_we   = bus.nes_wr;
            bus.sd_oeA  = bus.nes_rd_cpu;
            bus.sd_oeB  = bus.nes_rd_ppu;
        end else begin
            bus.sd_oeA  = 1'b0;
            bus.sd_oeB  = 1'b0;
        end
    end

    assign bus.nes_ce    = nes_ce_r;
    assign bus.run_nes   = (nes_ce_r == PH_RUN);
    assign bus.sd_clkref = nes_ce_r[1];
    assign bus.nes_reset = (state_r != RUN);
    assign bus.loaded    = (state_r == RUN);
    assign bus.ld_ready  = ld_ready_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_sdram_port_sched.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_sched
// Directed bench for sdram_port_sched. Accepted loader bytes are queued as
// expected writes; a negedge monitor pops them when a write slot starts and
// checks that sd_we only changes on slot boundaries.
// -----------------------------------------------------------------------------
module tb_sdram_port_sched;

    localparam int AW     = 22;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    logic clock;
    logic reset_n;
    logic [1:0] ph;
    int   errors;
    int   checks;
    exp_t exp_q[$];
    logic prev_valid;
    logic prev_we;
`ifdef SDRAM_VERIFY_EN
    logic [15:0] load_sum;
`endif

    sdram_port_sched_if #(.ADDR_W(AW)) bus ();

    sdram_port_sched #(
        .LD_FIFO_DEPTH (DEPTH),
        .SETTLE_SLOTS  (SETTLE),
        .ADDR_W        (AW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef SDRAM_VERIFY_EN
        ,
        .load_sum (load_sum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference phase: counts clocks since reset release.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ph <= 2'd0;
        else          ph <= ph + 2'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-slot monitor: scoreboard pop at slot start, hold check inside a slot.
    always @(negedge clock) begin
        if (reset_n && !bus.loaded) begin
            if (ph == 2'd0) begin
                if (bus.sd_we) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL unexpected_write observed addr=%0h expected none", bus.sd_addr);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(bus.sd_addr), 32'(e.addr));
                        chk("wr_data", 32'(bus.sd_din), 32'(e.data));
                    end
                end
            end else if (prev_valid) begin
                chk("slot_hold", 32'(bus.sd_we), 32'(prev_we));
            end
            prev_valid <= 1'b1;
            prev_we    <= bus.sd_we;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    task automatic push_byte(input logic [AW-1:0] a, input logic [7:0] d, input bit accepted);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        if (accepted) exp_q.push_back('{addr: a, data: d});
        @(negedge clock);
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_ph3();
        for (int i = 0; i < 8; i++) begin
            if (ph == 2'd3) break;
            @(negedge clock);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  run_cnt;
        int  hi;
        bit  found;
        bit  hold_ok;
        errors = 0;
        checks = 0;
        prev_valid = 1'b0;
        prev_we    = 1'b0;
        reset_n = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = 8'd0;
        bus.ld_done = 1'b0;  bus.reload = 1'b0;
        bus.nes_addr = '0;   bus.nes_rd_cpu = 1'b0; bus.nes_rd_ppu = 1'b0;
        bus.nes_wr = 1'b0;   bus.nes_dout = 8'd0;

        // ---- reset values ----
        @(negedge clock);
        chk("rst_nes_ce",    32'(bus.nes_ce),    32'd0);
        chk("rst_nes_reset", 32'(bus.nes_reset), 32'd1);
        chk("rst_sd_we",     32'(bus.sd_we),     32'd0);
        chk("rst_sd_addr",   32'(bus.sd_addr),   32'd0);
        chk("rst_sd_din",    32'(bus.sd_din),    32'd0);
        chk("rst_sd_oe",     32'({bus.sd_oeA, bus.sd_oeB}), 32'd0);
        chk("rst_ld_ready",  32'(bus.ld_ready),  32'd0);
        chk("rst_overflow",  32'(bus.overflow),  32'd0);
        chk("rst_loaded",    32'(bus.loaded),    32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("ld_ready_after_rst", 32'(bus.ld_ready), 32'd1);

        // ---- phase: run_nes every 4th clock, clkref = phase bit 1 ----
        chk("phase_start", 32'(bus.nes_ce), 32'(ph));
        run_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            chk("run_nes", 32'(bus.run_nes), 32'(ph == 2'd3));
            chk("sd_clkref", 32'(bus.sd_clkref), 32'(ph[1]));
            if (bus.run_nes) run_cnt++;
        end
        chk("run_nes_count", 32'(run_cnt), 32'd25);

        // ---- normal load: three spaced bytes then ld_done ----
        push_byte(22'h000010, 8'hA5, 1'b1);
        repeat (7) @(negedge clock);
        push_byte(22'h000011, 8'h5A, 1'b1);
        repeat (7) @(negedge clock);
        push_byte(22'h000012, 8'hFF, 1'b1);
        bus.ld_done = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !bus.sd_we) begin
                found = 1'b1;
                break;
            end
        end
        chk("drain_done", 32'(found), 32'd1);
        // One slot to see the port idle, then SETTLE slots of NES reset.
        hold_ok = bus.nes_reset;
        for (int k = 2; k <= (SETTLE + 1) * 4; k++) begin
            @(negedge clock);
            if (!bus.nes_reset) hold_ok = 1'b0;
        end
        chk("settle_hold", 32'(hold_ok), 32'd1);
        @(negedge clock);
        chk("run_nes_reset", 32'(bus.nes_reset), 32'd0);
        chk("run_loaded",    32'(bus.loaded),    32'd1);
        chk("run_ld_ready",  32'(bus.ld_ready),  32'd0);

        // ---- run mux: same-cycle pass-through ----
        bus.nes_addr = 22'h3FFFFF; bus.nes_wr = 1'b1; bus.nes_dout = 8'h42;
        #1;
        chk("mux_addr", 32'(bus.sd_addr), 32'h3FFFFF);
        chk("mux_we",   32'(bus.sd_we),   32'd1);
        chk("mux_din",  32'(bus.sd_din),  32'h42);
        chk("mux_oe_idle", 32'({bus.sd_oeA, bus.sd_oeB}), 32'd0);
        bus.nes_wr = 1'b0; bus.nes_rd_ppu = 1'b1; bus.nes_addr = 22'h012345;
        #1;
        chk("mux_oeB", 32'(bus.sd_oeB), 32'd1);
        chk("mux_oeA", 32'(bus.sd_oeA), 32'd0);
        chk("mux_we0", 32'(bus.sd_we),  32'd0);
        chk("mux_addr2", 32'(bus.sd_addr), 32'h012345);
        bus.nes_rd_ppu = 1'b0; bus.nes_rd_cpu = 1'b1;
        #1;
        chk("mux_oeA_cpu", 32'({bus.sd_oeA, bus.sd_oeB}), 32'd2);
        bus.nes_rd_cpu = 1'b0;

        // ---- reload from RUN with a NES write in progress ----
        @(negedge clock);
        bus.ld_done = 1'b0;
        bus.nes_wr  = 1'b1;
        bus.reload  = 1'b1;
        #1;
        chk("reload_pre_we", 32'(bus.sd_we), 32'd1);
        @(negedge clock);
        chk("reload_nes_reset", 32'(bus.nes_reset), 32'd1);
        chk("reload_sd_we",     32'(bus.sd_we),     32'd0);
        chk("reload_ld_ready",  32'(bus.ld_ready),  32'd1);
        chk("reload_overflow",  32'(bus.overflow),  32'd0);
        chk("reload_loaded",    32'(bus.loaded),    32'd0);
        bus.reload = 1'b0;
        bus.nes_wr = 1'b0;

        // ---- burst: four back-to-back pushes fill the FIFO, fifth overflows ----
        @(negedge clock);
        wait_ph3();
        push_byte(22'h000100, 8'h01, 1'b1);
        push_byte(22'h000101, 8'h82, 1'b1);
        push_byte(22'h000102, 8'h33, 1'b1);
        push_byte(22'h000103, 8'hC4, 1'b1);
        chk("burst_ld_ready_full", 32'(bus.ld_ready), 32'd0);
        chk("burst_no_ovf_yet",    32'(bus.overflow), 32'd0);
        push_byte(22'h000104, 8'hEE, 1'b0);
        chk("burst_overflow", 32'(bus.overflow), 32'd1);
        chk("burst_we_start", 32'(bus.sd_we),    32'd1);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.sd_we) hi++;
            else break;
        end
`ifdef SDRAM_VERIFY_EN
        chk("burst_we_len", 32'(hi), 32'd4);
        repeat (16) @(negedge clock);
`else
        chk("burst_we_len", 32'(hi), 32'd16);
`endif
        chk("burst_drained", 32'(exp_q.size()), 32'd0);
        chk("burst_ovf_sticky", 32'(bus.overflow), 32'd1);

        // ---- reload in LOAD clears overflow ----
        bus.reload = 1'b1;
        @(negedge clock);
        chk("reload2_overflow", 32'(bus.overflow), 32'd0);
        chk("reload2_ld_ready", 32'(bus.ld_ready), 32'd1);
        bus.reload = 1'b0;

        // ---- asynchronous reset in the middle of a write slot ----
        @(negedge clock);
        push_byte(22'h2AAAAA, 8'h99, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.sd_we) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("midwrite_slot_seen", 32'(found), 32'd1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_sd_we",     32'(bus.sd_we),     32'd0);
        chk("async_rst_nes_ce",    32'(bus.nes_ce),    32'd0);
        chk("async_rst_nes_reset", 32'(bus.nes_reset), 32'd1);
        chk("async_rst_ld_ready",  32'(bus.ld_ready),  32'd0);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("post_rst_loaded",   32'(bus.loaded),   32'd0);
        chk("post_rst_nes_ce",   32'(bus.nes_ce),   32'd1);
        chk("post_rst_sd_we",    32'(bus.sd_we),    32'd0);
        repeat (8) @(negedge clock);
        chk("post_rst_no_write", 32'(bus.sd_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
